// File: rtl/jzjpcc_fetch_stage.sv
// rtl/jzjpcc_fetch_stage.sv - RV32 instruction fetch stage: PC, SRAM addressing, 2-entry output buffer
module jzjpcc_fetch_stage #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          INSTR_ADDR_WIDTH = 14
) (
    input  logic                        clock,
    input  logic                        not_reset,
    output logic [INSTR_ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]                 imem_read_data,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instruction,
    output logic [31:0]                 out_pc
);

    // Fetch state: next PC to issue and the word currently being read by the SRAM
    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc;

    // Output buffer: two {instruction, pc} entries with wrap-around pointers
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic [31:0] redirect_addr;
    logic [31:0] issue_addr;
    logic        pop;
    logic        capture;
    logic        issue;
    logic [2:0]  occupancy;

    // Low address bits of a redirect are ignored; the masked value is what gets issued and tracked
    assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;
    assign issue_addr    = redirect_valid ? redirect_addr : pc;
    assign imem_address  = issue_addr[INSTR_ADDR_WIDTH+1:2];

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready & ~redirect_valid;
    assign capture   = inflight & ~redirect_valid;

    // Slots already claimed after this edge's pop; issuing only when a slot is free keeps the buffer from overflowing
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = redirect_valid | (occupancy < 3'd2);

    assign out_instruction = out_valid ? fifo_instr[head] : 32'h0000_0000;
    assign out_pc          = out_valid ? fifo_pc[head]    : 32'h0000_0000;

    // Issue, capture and pop bookkeeping; a redirect flushes the buffer and the inflight word
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0000_0000;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= 32'h0000_0000;
                fifo_pc[i]    <= 32'h0000_0000;
            end
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= issue_addr;
                pc          <= issue_addr + 32'd4;
            end else begin
                inflight    <= 1'b0;
            end

            if (redirect_valid) begin
                head  <= 1'b0;
                tail  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (capture) begin
                    fifo_instr[tail] <= imem_read_data;
                    fifo_pc[tail]    <= inflight_pc;
                    tail             <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
                count <= count + {1'b0, capture} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_jzjpcc_fetch_stage.sv
// tb/tb_jzjpcc_fetch_stage.sv - scoreboard bench for jzjpcc_fetch_stage
module tb_jzjpcc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          AW       = 14;

    logic          clock;
    logic          not_reset;
    logic [AW-1:0] imem_address;
    logic [31:0]   imem_read_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instruction;
    logic [31:0]   out_pc;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] next_push;

    jzjpcc_fetch_stage #(
        .RESET_PC(RESET_PC),
        .INSTR_ADDR_WIDTH(AW)
    ) dut (
        .clock(clock),
        .not_reset(not_reset),
        .imem_address(imem_address),
        .imem_read_data(imem_read_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_pc(out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: word i holds 32'h1000_0000 + i, one-cycle read latency
    always @(posedge clock) imem_read_data <= 32'h1000_0000 + {{(32-AW){1'b0}}, imem_address};

    function automatic logic [31:0] word_for(input logic [31:0] p);
        logic [31:0] idx;
        idx = (p >> 2) & 32'h0000_3FFF;
        return 32'h1000_0000 + idx;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] addr);
        exp_q.delete();
        next_push = addr & 32'hFFFF_FFFC;
        sb_top_up();
    endtask

    // Monitor: every accepted instruction must match the head of the expected stream; held output must stay stable
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    initial prev_hold = 1'b0;

    always @(negedge clock) begin
        logic [31:0] e;
        if (!not_reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_pc", out_pc, prev_pc);
                check("hold_instr", out_instruction, prev_instr);
            end
            if (!out_valid) begin
                check("idle_pc_zero", out_pc, 32'h0);
                check("idle_instr_zero", out_instruction, 32'h0);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", out_pc, e);
                    check("sb_instr", out_instruction, word_for(e));
                    n_pops++;
                    sb_top_up();
                end
            end
            prev_hold  = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_instr = out_instruction;
        end
    end

    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic release_and_check_latency(input string tag);
        @(negedge clock);
        not_reset = 1'b1;
        @(negedge clock);
        check({tag, "_e0_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clock);
        check({tag, "_e1_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_e1_pc"}, out_pc, RESET_PC);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int vcount;
        logic [AW-1:0] a_hold;
        int waited;

        not_reset      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        sb_restart(RESET_PC);

        repeat (2) @(negedge clock);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instruction, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_addr", {{(32-AW){1'b0}}, imem_address}, 32'(RESET_PC[AW+1:2]));

        release_and_check_latency("start");

        // Throughput: one instruction per cycle with out_ready high
        vcount = 0;
        repeat (16) begin
            @(negedge clock);
            if (out_valid) vcount++;
        end
        check("throughput", vcount, 16);

        // Stall: two buffered words, fetch address frozen two words past the head
        drive_edge();
        out_ready = 1'b0;
        repeat (4) @(negedge clock);
        a_hold = imem_address;
        @(negedge clock);
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_addr_frozen", {{(32-AW){1'b0}}, imem_address}, {{(32-AW){1'b0}}, a_hold});
        check("stall_addr", {{(32-AW){1'b0}}, imem_address},
              ((out_pc >> 2) + 32'd2) & 32'h0000_3FFF);
        drive_edge();
        out_ready = 1'b1;
        repeat (6) @(negedge clock);

        // Redirect while the buffer is full and decode is ready
        drive_edge();
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        drive_edge();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        sb_restart(32'h0000_0100);
        @(negedge clock);
        check("redir_addr", {{(32-AW){1'b0}}, imem_address}, 32'h0000_0040);
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("redir_bubble", {31'b0, out_valid}, 32'd0);
        @(negedge clock);
        check("redir_first_pc", out_pc, 32'h0000_0100);
        repeat (4) @(negedge clock);

        // Back-to-back redirects: only the second target is ever presented
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        sb_restart(32'h0000_0200);
        drive_edge();
        redirect_pc    = 32'h0000_0300;
        sb_restart(32'h0000_0300);
        @(negedge clock);
        check("b2b_bubble1", {31'b0, out_valid}, 32'd0);
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("b2b_bubble2", {31'b0, out_valid}, 32'd0);
        @(negedge clock);
        check("b2b_first_pc", out_pc, 32'h0000_0300);
        repeat (4) @(negedge clock);

        // PC wrap from the top of the address space
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        sb_restart(32'hFFFF_FFF8);
        drive_edge();
        redirect_valid = 1'b0;
        waited = 0;
        while (!(out_valid && out_pc == 32'h0) && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("wrap_reached", {31'b0, (waited < 20)}, 32'd1);
        check("wrap_instr", out_instruction, 32'h1000_0000);
        repeat (4) @(negedge clock);

        // Asynchronous reset in the middle of a stall
        drive_edge();
        out_ready = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        #2;
        not_reset = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_addr", {{(32-AW){1'b0}}, imem_address}, 32'(RESET_PC[AW+1:2]));
        sb_restart(RESET_PC);
        out_ready = 1'b1;
        @(negedge clock);
        release_and_check_latency("restart");
        repeat (6) @(negedge clock);

        check("pops_seen", {31'b0, (n_pops > 40)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
